sd_cmd_framer: RTL and testbench

- Command-framing stage that sits directly upstream of the SPI mux/engine pair and drives its status word and 48-bit data word.
- Accepts an SD command index plus a 32-bit argument from the bootstrap controller and computes the CRC7.
- Builds the 48-bit SD command frame, launches one microSD SPI operation and waits for operation-complete.
- Returns the 32-bit response, or flags a timeout.

---
 rtl/sd_cmd_framer.sv | 174 +++++++++++++++++
 tb/tb_sd_cmd_framer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_framer.sv
// rtl/sd_cmd_framer.sv - SD command framer: CRC7, 48-bit frame build, SPI launch, response/timeout capture
module sd_cmd_framer #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_WIDTH      = 16
) (
   input  logic        spi_clk_i,
   input  logic        spi_rst_i,
   input  logic        cmd_start_i,
   input  logic [5:0]  cmd_index_i,
   input  logic [31:0] cmd_arg_i,
   input  logic        cmd_wr_i,
   input  logic        cmd_rd_i,
   input  logic [2:0]  cmd_div_i,
   input  logic [2:0]  spi_flagreg_i,
   input  logic [31:0] spi_data_i,
   output logic [8:0]  spi_statusreg_o,
   output logic [47:0] spi_data_o,
   output logic        cmd_busy_o,
   output logic        cmd_done_o,
   output logic        cmd_timeout_o,
   output logic [31:0] cmd_resp_o,
   output logic [6:0]  cmd_crc_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRC,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TMO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

   state_t               state_q, state_n;
   logic [5:0]           index_q;
   logic [31:0]          arg_q;
   logic                 wr_q, rd_q;
   logic [2:0]           div_q;
   logic [39:0]          shift_q;
   logic [5:0]           bit_cnt_q;
   logic [6:0]           crc_q;
   logic [47:0]          data_q;
   logic [6:0]           crc_out_q;
   logic [31:0]          resp_q;
   logic                 timeout_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 armed_q;

   logic                 crc_fb;
   logic [6:0]           crc_n;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 op_done;
   logic                 expired;
   logic [8:0]           active_status;

   // Only OPERT_DONE matters here; the other engine flags are deliberately ignored.
   logic unused_flags;
   assign unused_flags = spi_flagreg_i[2] ^ spi_flagreg_i[0];

   assign crc_fb        = shift_q[39] ^ crc_q[6];
   assign crc_n         = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
   assign cnt_inc       = cnt_q + 1'b1;
   assign op_done       = armed_q & spi_flagreg_i[1];
   assign expired       = (cnt_inc == TMO_VAL);
   // microSD path select, divisor, direction, MSB-first; bit 0 is the operation strobe
   assign active_status = {2'b11, div_q, rd_q, wr_q, 1'b1, 1'b0};

   assign spi_data_o    = data_q;
   assign cmd_crc_o     = crc_out_q;
   assign cmd_resp_o    = resp_q;
   assign cmd_timeout_o = timeout_q;

   // State register
   always_ff @(posedge spi_clk_i) begin
      if (spi_rst_i) state_q <= S_IDLE;
      else           state_q <= state_n;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_n         = state_q;
      spi_statusreg_o = 9'd0;
      cmd_busy_o      = 1'b1;
      cmd_done_o      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_busy_o = 1'b0;
            if (cmd_start_i) state_n = S_CRC;
         end
         S_CRC: begin
            if (bit_cnt_q == 6'd0) state_n = S_ISSUE;
         end
         S_ISSUE: begin
            spi_statusreg_o = active_status | 9'd1;
            state_n         = S_WAIT;
         end
         S_WAIT: begin
            spi_statusreg_o = active_status;
            if (op_done || expired) state_n = S_DONE;
         end
         S_DONE: begin
            cmd_done_o = 1'b1;
            state_n    = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath: command latch, serial CRC7, frame build, completion/timeout capture
   always_ff @(posedge spi_clk_i) begin
      if (spi_rst_i) begin
         index_q   <= 6'd0;
         arg_q     <= 32'd0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         div_q     <= 3'd0;
         shift_q   <= 40'd0;
         bit_cnt_q <= 6'd0;
         crc_q     <= 7'd0;
         data_q    <= 48'd0;
         crc_out_q <= 7'd0;
         resp_q    <= 32'd0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_start_i) begin
                  index_q   <= cmd_index_i;
                  arg_q     <= cmd_arg_i;
                  wr_q      <= cmd_wr_i;
                  rd_q      <= cmd_rd_i;
                  div_q     <= cmd_div_i;
                  crc_q     <= 7'd0;
                  shift_q   <= {2'b01, cmd_index_i, cmd_arg_i};
                  bit_cnt_q <= 6'd39;
                  timeout_q <= 1'b0;
                  resp_q    <= 32'd0;
               end
            end
            S_CRC: begin
               crc_q     <= crc_n;
               shift_q   <= {shift_q[38:0], 1'b0};
               bit_cnt_q <= bit_cnt_q - 1'b1;
               if (bit_cnt_q == 6'd0) begin
                  data_q    <= {2'b01, index_q, arg_q, crc_n, 1'b1};
                  crc_out_q <= crc_n;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               armed_q <= 1'b0;
            end
            S_WAIT: begin
               // A done flag only counts after it has been seen low once this command.
               if (op_done) begin
                  resp_q <= spi_data_i;
               end else begin
                  cnt_q <= cnt_inc;
                  if (!spi_flagreg_i[1]) armed_q <= 1'b1;
                  if (expired) begin
                     resp_q    <= 32'hFFFF_FFFF;
                     timeout_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// tb/tb_sd_cmd_framer.sv - randomized self-checking bench for sd_cmd_framer
module tb_sd_cmd_framer;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        spi_rst;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_wr, cmd_rd;
   logic [2:0]  cmd_div;
   logic [2:0]  spi_flagreg;
   logic [31:0] spi_data_in;
   logic [8:0]  spi_statusreg;
   logic [47:0] spi_data_out;
   logic        cmd_busy, cmd_done, cmd_timeout;
   logic [31:0] cmd_resp;
   logic [6:0]  cmd_crc;

   always #5 clk = ~clk;

   sd_cmd_framer #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
      .spi_clk_i       (clk),
      .spi_rst_i       (spi_rst),
      .cmd_start_i     (cmd_start),
      .cmd_index_i     (cmd_index),
      .cmd_arg_i       (cmd_arg),
      .cmd_wr_i        (cmd_wr),
      .cmd_rd_i        (cmd_rd),
      .cmd_div_i       (cmd_div),
      .spi_flagreg_i   (spi_flagreg),
      .spi_data_i      (spi_data_in),
      .spi_statusreg_o (spi_statusreg),
      .spi_data_o      (spi_data_out),
      .cmd_busy_o      (cmd_busy),
      .cmd_done_o      (cmd_done),
      .cmd_timeout_o   (cmd_timeout),
      .cmd_resp_o      (cmd_resp),
      .cmd_crc_o       (cmd_crc)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // expected outputs for the current cycle
   logic [8:0]  e_status;
   logic [47:0] e_data;
   logic        e_busy, e_done, e_to;
   logic [31:0] e_resp;
   logic [6:0]  e_crc;

   // held values from the previous command
   logic [47:0] p_data;
   logic [6:0]  p_crc;
   logic [31:0] p_resp;
   logic        p_to;

   // current command prediction; cycle 0 is the first cycle after the start edge
   logic [47:0] c_frame;
   logic [6:0]  c_crc;
   logic [8:0]  c_stat;
   int          c_k;
   logic [31:0] c_resp;
   logic        c_to;
   int          c_rst;

   bit          fl [0:79];
   logic [31:0] dseq [0:79];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // CRC7 as polynomial long division of msg*x^7 by x^7+x^3+1
   function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
      logic [46:0] r;
      r = {msg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("status",  64'(spi_statusreg), 64'(e_status));
         chk("frame",   64'(spi_data_out),  64'(e_data));
         chk("busy",    64'(cmd_busy),      64'(e_busy));
         chk("done",    64'(cmd_done),      64'(e_done));
         chk("timeout", 64'(cmd_timeout),   64'(e_to));
         chk("resp",    64'(cmd_resp),      64'(e_resp));
         chk("crc",     64'(cmd_crc),       64'(e_crc));
      end
   end

   task automatic set_idle_exp();
      e_status = 9'd0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_data   = p_data;
      e_crc    = p_crc;
      e_resp   = p_resp;
      e_to     = p_to;
   endtask

   task automatic set_cyc_exp(input int c);
      if (c_rst >= 0 && c > c_rst) begin
         e_status = 9'd0; e_busy = 1'b0; e_done = 1'b0;
         e_data = 48'd0; e_crc = 7'd0; e_resp = 32'd0; e_to = 1'b0;
      end else begin
         e_busy   = (c <= 42 + c_k);
         e_done   = (c == 42 + c_k);
         if (c == 40)                        e_status = c_stat;
         else if (c >= 41 && c <= 41 + c_k)  e_status = {c_stat[8:1], 1'b0};
         else                                e_status = 9'd0;
         e_data   = (c >= 40) ? c_frame : p_data;
         e_crc    = (c >= 40) ? c_crc : p_crc;
         e_resp   = (c >= 42 + c_k) ? c_resp : 32'd0;
         e_to     = (c >= 42 + c_k) ? c_to : 1'b0;
      end
   endtask

   // kind 0: low p1 WAIT cycles then high; 1: high p1, low p2, high; 2: constant p1;
   // 3: low until the last allowed WAIT cycle; 4: random
   task automatic fill(input int kind, input int p1, input int p2);
      for (int c = 0; c < 80; c++) begin
         int m;
         dseq[c] = $urandom;
         m = c - 41;
         if (c < 41) fl[c] = 1'($urandom_range(0, 1));
         else case (kind)
            0: fl[c] = (m >= p1);
            1: fl[c] = (m < p1) ? 1'b1 : ((m < p1 + p2) ? 1'b0 : 1'b1);
            2: fl[c] = 1'(p1);
            3: fl[c] = (m >= TMO - 1);
            default: fl[c] = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   // rst_at/xstart: -1 none, -2 random within the busy window
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic wr,
                          input logic rd, input logic [2:0] div, input int rst_at, input int xstart);
      logic [39:0] msg;
      bit seen_low;
      int last, ra, xs;
      msg     = {2'b01, idx, arg};
      c_crc   = crc7_ref(msg);
      c_frame = {msg, c_crc, 1'b1};
      c_stat  = {2'b11, div, rd, wr, 2'b11};
      c_k = TMO - 1; c_resp = 32'hFFFF_FFFF; c_to = 1'b1; seen_low = 1'b0;
      for (int m = 0; m < TMO; m++) begin
         if (seen_low && fl[41 + m]) begin
            c_k = m; c_resp = dseq[41 + m]; c_to = 1'b0;
            break;
         end
         if (!fl[41 + m]) seen_low = 1'b1;
      end
      ra = (rst_at == -2) ? int'($urandom_range(0, 42 + c_k)) : rst_at;
      xs = (xstart == -2) ? int'($urandom_range(0, 42 + c_k)) : xstart;
      c_rst = ra;
      set_idle_exp();
      cmd_start = 1'b1; cmd_index = idx; cmd_arg = arg;
      cmd_wr = wr; cmd_rd = rd; cmd_div = div;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      last = (ra >= 0) ? ra + 1 : 43 + c_k;
      for (int c = 0; c <= last; c++) begin
         set_cyc_exp(c);
         spi_flagreg = {1'($urandom_range(0, 1)), fl[c], 1'($urandom_range(0, 1))};
         spi_data_in = dseq[c];
         cmd_start   = (c == xs) && (ra < 0 || c <= ra) && (c <= 42 + c_k);
         cmd_index   = 6'($urandom);
         cmd_arg     = $urandom;
         spi_rst     = (c == ra);
         @(posedge clk); #1;
      end
      spi_rst = 1'b0; cmd_start = 1'b0;
      if (ra >= 0) begin
         p_data = 48'd0; p_crc = 7'd0; p_resp = 32'd0; p_to = 1'b0;
      end else begin
         p_data = c_frame; p_crc = c_crc; p_resp = c_resp; p_to = c_to;
      end
      set_idle_exp();
   endtask

   initial begin
      logic [31:0] bnd_resp;
      spi_rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0;
      cmd_wr = 1'b0; cmd_rd = 1'b0; cmd_div = '0; spi_flagreg = '0; spi_data_in = '0;
      p_data = '0; p_crc = '0; p_resp = '0; p_to = 1'b0;
      c_rst = -1; c_k = 0;
      repeat (3) @(posedge clk);
      #1;
      set_idle_exp();
      chk_en = 1'b1;
      @(posedge clk); #1;
      spi_rst = 1'b0;
      @(posedge clk); #1;

      // model pins
      chk("model_crc_cmd0", 64'(crc7_ref(40'h40_0000_0000)), 64'h4A);
      chk("model_crc_cmd8", 64'(crc7_ref(40'h48_0000_01AA)), 64'h43);

      // CMD0
      fill(0, 3, 0);
      run_cmd(6'd0, 32'd0, 1'b0, 1'b0, 3'd0, -1, -1);
      chk("cmd0_crc",   64'(cmd_crc), 64'h4A);
      chk("cmd0_frame", 64'(spi_data_out), 64'h40_0000_0000_95);

      // CMD8 with a fixed engine response
      fill(0, 2, 0);
      for (int c = 0; c < 80; c++) dseq[c] = 32'h0000_01AA;
      run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 3'b100, -1, -1);
      chk("cmd8_crc",   64'(cmd_crc), 64'h43);
      chk("cmd8_frame", 64'(spi_data_out), 64'h48_0000_01AA_87);
      chk("cmd8_resp",  64'(cmd_resp), 64'h1AA);
      chk("cmd8_tmo",   64'(cmd_timeout), 64'h0);

      // stale OPERT_DONE: high through ISSUE and 5 WAIT cycles, low 3, then high
      fill(1, 5, 3);
      fl[40] = 1'b1;
      run_cmd(6'd17, $urandom, 1'b0, 1'b1, 3'd2, -1, -1);
      chk("stale_k", 64'(c_k), 64'd8);

      // timeout
      fill(2, 0, 0);
      run_cmd(6'd55, $urandom, 1'b1, 1'b0, 3'd1, -1, -1);
      chk("tmo_k",    64'(c_k), 64'(TMO - 1));
      chk("tmo_resp", 64'(cmd_resp), 64'hFFFF_FFFF);
      chk("tmo_flag", 64'(cmd_timeout), 64'h1);

      // completion on the same cycle the counter expires
      fill(3, 0, 0);
      bnd_resp = dseq[41 + TMO - 1];
      run_cmd(6'd41, $urandom, 1'b0, 1'b1, 3'd7, -1, -1);
      chk("bnd_tmo",  64'(cmd_timeout), 64'h0);
      chk("bnd_resp", 64'(cmd_resp), 64'(bnd_resp));

      // reset mid-CRC with an extra start while busy
      fill(0, 4, 0);
      run_cmd(6'd12, $urandom, 1'b1, 1'b1, 3'd3, 20, 10);
      chk("rst_crc_busy",  64'(cmd_busy), 64'h0);
      chk("rst_crc_frame", 64'(spi_data_out), 64'h0);

      // reset mid-WAIT with an extra start while busy
      fill(2, 0, 0);
      run_cmd(6'd24, $urandom, 1'b1, 1'b0, 3'd5, 44, 42);
      chk("rst_wait_busy",   64'(cmd_busy), 64'h0);
      chk("rst_wait_status", 64'(spi_statusreg), 64'h0);

      // start presented during DONE is ignored
      fill(0, 2, 0);
      run_cmd(6'd9, $urandom, 1'b0, 1'b1, 3'd6, -1, 44);

      // randomized commands
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 4);
         fill(kind, (kind == 2) ? int'($urandom_range(0, 1)) : int'($urandom_range(1, 8)),
              int'($urandom_range(1, 3)));
         run_cmd(6'($urandom), $urandom, 1'($urandom), 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 7) == 0) ? -2 : -1,
                 ($urandom_range(0, 2) == 0) ? -2 : -1);
      end

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
